// File: rtl/crossy_pkg.sv
// Shared types and constants for the crossy game sequencer.
// Optional feature macro: CROSSY_DIFFICULTY_EN (used by crossy_game_ctrl).
package crossy_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_HIT  = 2'd2,
        S_WIN  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MV_NONE  = 2'd0,
        MV_UP    = 2'd1,
        MV_LEFT  = 2'd2,
        MV_RIGHT = 2'd3
    } move_t;

    localparam logic [7:0] SCORE_MAX = 8'd255;

    function automatic logic [31:0] center_onehot(input int width);
        logic [31:0] v;
        v = '0;
        v[width / 2] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/crossy_btn_arb.sv
// Button edge detection, fixed-priority arbitration (up > left > right)
// and post-move cooldown; emits at most one move code per cycle.
module crossy_btn_arb
    import crossy_pkg::*;
#(
    parameter int MOVE_COOLDOWN = 5_000_000
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  i_btn_left,
    input  logic  i_btn_right,
    input  logic  i_btn_up,
    input  logic  i_accept,
    output move_t o_move
);

    localparam int CW = (MOVE_COOLDOWN > 1) ? $clog2(MOVE_COOLDOWN) : 1;
    localparam logic [CW-1:0] COOL_LOAD =
        (MOVE_COOLDOWN > 0) ? CW'(MOVE_COOLDOWN - 1) : '0;

    logic          r_left_q;
    logic          r_right_q;
    logic          r_up_q;
    logic [CW-1:0] r_cool;

    logic w_edge_l;
    logic w_edge_r;
    logic w_edge_u;
    logic w_sel_u;
    logic w_sel_l;
    logic w_sel_r;

    assign w_edge_l = i_btn_left  & ~r_left_q;
    assign w_edge_r = i_btn_right & ~r_right_q;
    assign w_edge_u = i_btn_up    & ~r_up_q;

    // losing or cooled-down edges are simply dropped, never queued
    assign w_sel_u = (r_cool == '0) & w_edge_u;
    assign w_sel_l = (r_cool == '0) & w_edge_l & ~w_edge_u;
    assign w_sel_r = (r_cool == '0) & w_edge_r & ~w_edge_l & ~w_edge_u;

    always_comb begin
        o_move = MV_NONE;
        unique case (1'b1)
            w_sel_u: o_move = MV_UP;
            w_sel_l: o_move = MV_LEFT;
            w_sel_r: o_move = MV_RIGHT;
            default: o_move = MV_NONE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_left_q  <= 1'b0;
            r_right_q <= 1'b0;
            r_up_q    <= 1'b0;
            r_cool    <= '0;
        end else begin
            r_left_q  <= i_btn_left;
            r_right_q <= i_btn_right;
            r_up_q    <= i_btn_up;
            if (i_accept && o_move != MV_NONE)
                r_cool <= COOL_LOAD;
            else if (r_cool != '0)
                r_cool <= r_cool - 1'b1;
        end
    end

endmodule

// File: rtl/crossy_game_ctrl.sv
// Crossy game sequencer: FSM, lane-scroll tick, player position and collision.
// Define CROSSY_DIFFICULTY_EN to shorten the scroll period as score grows.
module crossy_game_ctrl
    import crossy_pkg::*;
#(
    parameter int WIDTH         = 3,
    parameter int NUM_ROWS      = 3,
    parameter int TICK_DIV      = 25_000_000,
    parameter int MOVE_COOLDOWN = 5_000_000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        btn_left,
    input  logic                        btn_right,
    input  logic                        btn_up,
    input  logic [NUM_ROWS*WIDTH-1:0]   hazard,
    output logic                        scroll_tick,
    output logic [WIDTH-1:0]            pos,
    output logic [$clog2(NUM_ROWS)-1:0] row_idx,
    output logic [1:0]                  state,
    output logic [7:0]                  score
);

    localparam int RW = $clog2(NUM_ROWS);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [WIDTH-1:0] CENTER = WIDTH'(center_onehot(WIDTH));
    localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);

    state_t         r_state;
    logic [WIDTH-1:0] r_pos;
    logic [RW-1:0]  r_row;
    logic [7:0]     r_score;
    logic [TW-1:0]  r_tick;
    logic [TW-1:0]  r_last;

    state_t         w_state_nxt;
    logic [WIDTH-1:0] w_pos_nxt;
    logic [RW-1:0]  w_row_nxt;
    logic [7:0]     w_score_nxt;
    logic [WIDTH-1:0] w_row_haz;
    logic [TW-1:0]  w_last_nxt;
    logic           w_hit;
    logic           w_wrap;
    logic           w_accept;
    move_t          w_move;

    crossy_btn_arb #(
        .MOVE_COOLDOWN(MOVE_COOLDOWN)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .i_btn_left (btn_left),
        .i_btn_right(btn_right),
        .i_btn_up   (btn_up),
        .i_accept   (w_accept),
        .o_move     (w_move)
    );

    always_comb begin
        w_row_haz = '0;
        for (int r = 0; r < NUM_ROWS; r++)
            if (r_row == RW'(r))
                w_row_haz = hazard[r*WIDTH +: WIDTH];
    end

    assign w_hit  = |(w_row_haz & r_pos);
    assign w_wrap = (r_tick == r_last);

`ifdef CROSSY_DIFFICULTY_EN
    always_comb begin
        int sh;
        int per;
        sh  = (r_score > 8'd3) ? 3 : int'(r_score);
        per = TICK_DIV >> sh;
        if (per < 2)
            per = 2;
        w_last_nxt = TW'(per - 1);
    end
`else
    assign w_last_nxt = TLAST;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_row_nxt   = r_row;
        w_score_nxt = r_score;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_move != MV_NONE)
                    w_state_nxt = S_PLAY;
            end
            S_PLAY: begin
                // a collision wins over any move sampled in the same cycle
                if (w_hit) begin
                    w_state_nxt = S_HIT;
                end else begin
                    w_accept = (w_move != MV_NONE);
                    case (w_move)
                        MV_UP: begin
                            if (r_row == RW'(NUM_ROWS - 1)) begin
                                if (r_score != SCORE_MAX)
                                    w_score_nxt = r_score + 8'd1;
                                w_row_nxt   = '0;
                                w_pos_nxt   = CENTER;
                                w_state_nxt = S_WIN;
                            end else begin
                                w_row_nxt = r_row + 1'b1;
                            end
                        end
                        MV_LEFT: begin
                            if (!r_pos[WIDTH-1])
                                w_pos_nxt = {r_pos[WIDTH-2:0], 1'b0};
                        end
                        MV_RIGHT: begin
                            if (!r_pos[0])
                                w_pos_nxt = {1'b0, r_pos[WIDTH-1:1]};
                        end
                        default: ;
                    endcase
                end
            end
            S_WIN: w_state_nxt = S_PLAY;
            S_HIT: begin
                if (w_move != MV_NONE) begin
                    w_state_nxt = S_IDLE;
                    w_score_nxt = '0;
                    w_pos_nxt   = CENTER;
                    w_row_nxt   = '0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pos   <= CENTER;
            r_row   <= '0;
            r_score <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pos   <= w_pos_nxt;
            r_row   <= w_row_nxt;
            r_score <= w_score_nxt;
        end
    end

    // the counter only runs in PLAY; WIN and HIT hold it, IDLE keeps it at 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick <= '0;
            r_last <= TLAST;
        end else if (r_state == S_PLAY) begin
            if (w_wrap) begin
                r_tick <= '0;
                r_last <= w_last_nxt;
            end else begin
                r_tick <= r_tick + 1'b1;
            end
        end else if (r_state == S_IDLE || w_state_nxt == S_IDLE) begin
            r_tick <= '0;
        end
    end

    assign scroll_tick = (r_state == S_PLAY) && w_wrap;
    assign pos         = r_pos;
    assign row_idx     = r_row;
    assign state       = r_state;
    assign score       = r_score;

endmodule

// File: tb/tb_crossy_game_ctrl.sv
// Randomized bench for crossy_game_ctrl against a column/row reference model.
// Directed test-plan steps run first, then random buttons and hazards.
module tb_crossy_game_ctrl;

    localparam int W  = 3;
    localparam int NR = 3;
    localparam int TD = 4;
    localparam int MC = 2;
    localparam int CCOL = W - 1 - W / 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          btn_left;
    logic          btn_right;
    logic          btn_up;
    logic [NR*W-1:0] hazard;
    logic          scroll_tick;
    logic [W-1:0]  pos;
    logic [1:0]    row_idx;
    logic [1:0]    state;
    logic [7:0]    score;

    int n_vec = 0;
    int n_bad = 0;

    int m_mode;
    int m_col;
    int m_row;
    int m_score;
    int m_phase;
    int m_cool;
    bit m_pu;
    bit m_pl;
    bit m_pr;

    crossy_game_ctrl #(
        .WIDTH(W),
        .NUM_ROWS(NR),
        .TICK_DIV(TD),
        .MOVE_COOLDOWN(MC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_up     (btn_up),
        .hazard     (hazard),
        .scroll_tick(scroll_tick),
        .pos        (pos),
        .row_idx    (row_idx),
        .state      (state),
        .score      (score)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_col   = CCOL;
        m_row   = 0;
        m_score = 0;
        m_phase = 0;
        m_cool  = 0;
        m_pu    = 0;
        m_pl    = 0;
        m_pr    = 0;
    endtask

    task automatic model_step();
        bit eu, el, er, hit, acc;
        int mv;
        eu = btn_up && !m_pu;
        el = btn_left && !m_pl;
        er = btn_right && !m_pr;
        m_pu = btn_up;
        m_pl = btn_left;
        m_pr = btn_right;
        mv = 0;
        if (m_cool == 0) begin
            if (eu)      mv = 1;
            else if (el) mv = 2;
            else if (er) mv = 3;
        end
        acc = 0;
        hit = hazard[m_row * W + (W - 1 - m_col)];
        case (m_mode)
            0: if (mv != 0) m_mode = 1;
            1: begin
                m_phase = (m_phase + 1) % TD;
                if (hit) m_mode = 2;
                else if (mv == 1) begin
                    acc = 1;
                    if (m_row == NR - 1) begin
                        m_score = (m_score < 255) ? m_score + 1 : 255;
                        m_row = 0;
                        m_col = CCOL;
                        m_mode = 3;
                    end else m_row++;
                end else if (mv == 2) begin
                    acc = 1;
                    if (m_col > 0) m_col--;
                end else if (mv == 3) begin
                    acc = 1;
                    if (m_col < W - 1) m_col++;
                end
            end
            3: m_mode = 1;
            default: if (mv != 0) begin
                m_mode = 0;
                m_score = 0;
                m_col = CCOL;
                m_row = 0;
                m_phase = 0;
            end
        endcase
        if (acc) m_cool = (MC > 0) ? MC - 1 : 0;
        else if (m_cool > 0) m_cool--;
    endtask

    task automatic compare_all();
        chk("state", 32'(state), 32'(m_mode));
        chk("pos", 32'(pos), 32'(1 << (W - 1 - m_col)));
        chk("row", 32'(row_idx), 32'(m_row));
        chk("score", 32'(score), 32'(m_score));
        chk("tick", 32'(scroll_tick), 32'(m_mode == 1 && m_phase == TD - 1));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic press(input int which);
        btn_up    = (which == 1);
        btn_left  = (which == 2);
        btn_right = (which == 3);
        cyc();
        btn_up = 0;
        btn_left = 0;
        btn_right = 0;
    endtask

    task automatic async_reset();
        #2 reset = 1;
        #1;
        model_reset();
        chk("rst_state", 32'(state), 0);
        chk("rst_pos", 32'(pos), 32'b010);
        chk("rst_row", 32'(row_idx), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_tick", 32'(scroll_tick), 0);
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        int ticks;
        reset = 1;
        btn_left = 0;
        btn_right = 0;
        btn_up = 0;
        hazard = '0;
        model_reset();
        #1;
        chk("init_state", 32'(state), 0);
        chk("init_pos", 32'(pos), 32'b010);
        chk("init_row", 32'(row_idx), 0);
        chk("init_score", 32'(score), 0);
        chk("init_tick", 32'(scroll_tick), 0);
        @(negedge clk);
        reset = 0;

        press(1);
        chk("start_state", 32'(state), 1);
        chk("start_pos", 32'(pos), 32'b010);

        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            ticks += int'(scroll_tick);
        end
        chk("tick_count", 32'(ticks), 5);

        press(2);
        chk("left1", 32'(pos), 32'b100);
        cyc();
        press(2);
        chk("left_sat", 32'(pos), 32'b100);
        cyc();
        press(3);
        chk("right1", 32'(pos), 32'b010);
        cyc();
        btn_right = 1;
        for (int i = 0; i < 10; i++) cyc();
        btn_right = 0;
        chk("right_hold", 32'(pos), 32'b001);
        cyc();
        cyc();

        btn_left = 1;
        btn_up = 1;
        cyc();
        chk("arb_row", 32'(row_idx), 1);
        chk("arb_pos", 32'(pos), 32'b001);
        press(3);
        chk("cool_drop", 32'(pos), 32'b001);
        cyc();

        press(1);
        cyc();
        cyc();
        press(1);
        chk("win_state", 32'(state), 3);
        cyc();
        chk("win_after", 32'(state), 1);
        chk("win_score", 32'(score), 1);
        chk("win_pos", 32'(pos), 32'b010);
        cyc();

        hazard = 9'b000_000_010;
        cyc();
        chk("hit_state", 32'(state), 2);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("hit_notick", 32'(scroll_tick), 0);
        end
        hazard = '0;
        press(1);
        chk("hit_exit", 32'(state), 0);
        chk("hit_score", 32'(score), 0);
        press(1);
        cyc();
        cyc();
        async_reset();
        cyc();

        for (int i = 0; i < 3000; i++) begin
            btn_up    = ($urandom_range(0, 3) == 0);
            btn_left  = ($urandom_range(0, 3) == 0);
            btn_right = ($urandom_range(0, 3) == 0);
            hazard    = ($urandom_range(0, 9) == 0) ? NR*W'($urandom) : '0;
            if ($urandom_range(0, 299) == 0)
                async_reset();
            else
                cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
